taillight_sequencer: RTL and testbench

- Consumes the one-cycle 1 Hz pulse `Out` from the existing timer, fed here as `Tick`.
- Drives the six Thunderbird taillight lamps: three left (LA..LC), three right (RA..RC).
- Moore FSM; advances only on qualified ticks.
- Switch inputs come from board slide switches and are synchronized internally.

---
 rtl/taillight_sequencer.sv | 153 +++++++++++++++
 tb/tb_taillight_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/taillight_sequencer.sv
// Thunderbird taillight sequencer: synchronized switches, tick prescaler, Moore FSM.
// Optional macro TAILLIGHT_BRAKE_EN adds a Brake input that lights the idle lamp group.
module taillight_sequencer #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TICKS_PER_STEP = 1
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       Tick,
    input  logic       Left,
    input  logic       Right,
    input  logic       Hazard,
`ifdef TAILLIGHT_BRAKE_EN
    input  logic       Brake,
`endif
    output logic [2:0] L,
    output logic [2:0] R,
    output logic       Busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_L1, S_L2, S_L3, S_R1, S_R2, S_R3, S_HAZ
    } state_t;

    localparam logic [7:0] LP_LAST = 8'(TICKS_PER_STEP - 1);

    logic [SYNC_STAGES-1:0] r_sync_l;
    logic [SYNC_STAGES-1:0] r_sync_r;
    logic [SYNC_STAGES-1:0] r_sync_h;
    logic [7:0]             r_cnt;
    state_t                 r_state;
    logic [2:0]             r_l;
    logic [2:0]             r_r;
    logic                   r_busy;

    logic   w_sl;
    logic   w_sr;
    logic   w_sh;
    logic   w_haz_req;
    logic   w_step;
    state_t w_next;

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            r_sync_l <= '0;
            r_sync_r <= '0;
            r_sync_h <= '0;
        end else begin
            r_sync_l <= {r_sync_l[SYNC_STAGES-2:0], Left};
            r_sync_r <= {r_sync_r[SYNC_STAGES-2:0], Right};
            r_sync_h <= {r_sync_h[SYNC_STAGES-2:0], Hazard};
        end
    end

    assign w_sl      = r_sync_l[SYNC_STAGES-1];
    assign w_sr      = r_sync_r[SYNC_STAGES-1];
    assign w_sh      = r_sync_h[SYNC_STAGES-1];
    assign w_haz_req = w_sh | (w_sl & w_sr);

    // With TICKS_PER_STEP = 1 the counter stays at 0, so step degenerates to Tick.
    assign w_step = Tick && (r_cnt == LP_LAST);

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            r_cnt <= '0;
        end else if (Tick) begin
            if (r_cnt == LP_LAST) r_cnt <= '0;
            else                  r_cnt <= r_cnt + 8'd1;
        end
    end

    always_comb begin
        w_next = S_IDLE;
        unique case (r_state)
            S_IDLE: begin
                if (w_haz_req) w_next = S_HAZ;
                else if (w_sl) w_next = S_L1;
                else if (w_sr) w_next = S_R1;
            end
            S_L1: begin
                if (w_haz_req) w_next = S_HAZ;
                else if (w_sl) w_next = S_L2;
            end
            S_L2: begin
                if (w_haz_req) w_next = S_HAZ;
                else if (w_sl) w_next = S_L3;
            end
            S_R1: begin
                if (w_haz_req) w_next = S_HAZ;
                else if (w_sr) w_next = S_R2;
            end
            S_R2: begin
                if (w_haz_req) w_next = S_HAZ;
                else if (w_sr) w_next = S_R3;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
            r_l     <= '0;
            r_r     <= '0;
            r_busy  <= 1'b0;
        end else if (w_step) begin
            r_state <= w_next;
            r_busy  <= (w_next != S_IDLE);
            unique case (w_next)
                S_L1:    begin r_l <= 3'b001; r_r <= 3'b000; end
                S_L2:    begin r_l <= 3'b011; r_r <= 3'b000; end
                S_L3:    begin r_l <= 3'b111; r_r <= 3'b000; end
                S_R1:    begin r_l <= 3'b000; r_r <= 3'b001; end
                S_R2:    begin r_l <= 3'b000; r_r <= 3'b011; end
                S_R3:    begin r_l <= 3'b000; r_r <= 3'b111; end
                S_HAZ:   begin r_l <= 3'b111; r_r <= 3'b111; end
                default: begin r_l <= 3'b000; r_r <= 3'b000; end
            endcase
        end
    end

    assign Busy = r_busy;

`ifdef TAILLIGHT_BRAKE_EN
    logic [SYNC_STAGES-1:0] r_sync_b;
    logic                   w_sb;

    always_ff @(posedge Clock) begin
        if (!Reset_n) r_sync_b <= '0;
        else          r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], Brake};
    end

    assign w_sb = r_sync_b[SYNC_STAGES-1];

    always_comb begin
        L = r_l;
        R = r_r;
        if (w_sb && r_state != S_HAZ) begin
            if (r_state inside {S_L1, S_L2, S_L3})      R = '1;
            else if (r_state inside {S_R1, S_R2, S_R3}) L = '1;
            else begin
                L = '1;
                R = '1;
            end
        end
    end
`else
    assign L = r_l;
    assign R = r_r;
`endif

endmodule

// File: tb/tb_taillight_sequencer.sv
// Self-checking bench: two parameterizations driven in parallel against a lamp-level model.
module tb_taillight_sequencer;

    logic       Clock = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Tick = 1'b0;
    logic       Left = 1'b0;
    logic       Right = 1'b0;
    logic       Hazard = 1'b0;
    logic       Brake = 1'b0;
    logic [2:0] L0, R0, L1, R1;
    logic       B0, B1;

    int n_tests = 0;
    int n_fail  = 0;

    always #10 Clock = ~Clock;

    taillight_sequencer #(.SYNC_STAGES(2), .TICKS_PER_STEP(1)) u_dut0 (
        .Clock(Clock), .Reset_n(Reset_n), .Tick(Tick),
        .Left(Left), .Right(Right), .Hazard(Hazard),
`ifdef TAILLIGHT_BRAKE_EN
        .Brake(Brake),
`endif
        .L(L0), .R(R0), .Busy(B0)
    );

    taillight_sequencer #(.SYNC_STAGES(3), .TICKS_PER_STEP(3)) u_dut1 (
        .Clock(Clock), .Reset_n(Reset_n), .Tick(Tick),
        .Left(Left), .Right(Right), .Hazard(Hazard),
`ifdef TAILLIGHT_BRAKE_EN
        .Brake(Brake),
`endif
        .L(L1), .R(R1), .Busy(B1)
    );

    // Model: lamps as integers, sync as input history, prescale as a tick count.
    int SY[2]  = '{2, 3};
    int TPS[2] = '{1, 3};
    bit hl[2][4], hr[2][4], hh[2][4], hb[2][4];
    int mcnt[2], ml[2], mr[2];
    bit m_stp;
    int m_nl, m_nr;

    function automatic void next_lamps(input int l, input int r, input bit sl, input bit sr,
                                       input bit sh, output int nl, output int nr);
        nl = 0;
        nr = 0;
        if (l == 7 || r == 7) begin
            nl = 0;
        end else if (sh || (sl && sr)) begin
            nl = 7;
            nr = 7;
        end else if (sl && r == 0) begin
            nl = l * 2 + 1;
        end else if (sr && l == 0) begin
            nr = r * 2 + 1;
        end
    endfunction

    always @(posedge Clock) begin
        for (int k = 0; k < 2; k++) begin
            if (!Reset_n) begin
                for (int s = 0; s < 4; s++) begin
                    hl[k][s] = 0; hr[k][s] = 0; hh[k][s] = 0; hb[k][s] = 0;
                end
                mcnt[k] = 0;
                ml[k] = 0;
                mr[k] = 0;
            end else begin
                m_stp = 0;
                if (Tick) begin
                    mcnt[k] = mcnt[k] + 1;
                    if (mcnt[k] == TPS[k]) begin
                        mcnt[k] = 0;
                        m_stp = 1;
                    end
                end
                if (m_stp) begin
                    next_lamps(ml[k], mr[k], hl[k][SY[k]-1], hr[k][SY[k]-1], hh[k][SY[k]-1],
                               m_nl, m_nr);
                    ml[k] = m_nl;
                    mr[k] = m_nr;
                end
                for (int s = 3; s > 0; s--) begin
                    hl[k][s] = hl[k][s-1]; hr[k][s] = hr[k][s-1];
                    hh[k][s] = hh[k][s-1]; hb[k][s] = hb[k][s-1];
                end
                hl[k][0] = Left; hr[k][0] = Right; hh[k][0] = Hazard; hb[k][0] = Brake;
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_tests = n_tests + 1;
        if (got != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
        end
    endtask

    int el, er, eb;
    always @(negedge Clock) begin
        for (int k = 0; k < 2; k++) begin
            el = ml[k];
            er = mr[k];
            eb = (ml[k] != 0 || mr[k] != 0) ? 1 : 0;
            if (hb[k][SY[k]-1] && !(el == 7 && er == 7)) begin
                if (el != 0)      er = 7;
                else if (er != 0) el = 7;
                else begin el = 7; er = 7; end
            end
            if (k == 0) begin
                chk("model_L0", int'(L0), el); chk("model_R0", int'(R0), er);
                chk("model_B0", int'(B0), eb);
            end else begin
                chk("model_L1", int'(L1), el); chk("model_R1", int'(R1), er);
                chk("model_B1", int'(B1), eb);
            end
        end
    end

    task automatic pulse(input int gap);
        repeat (gap) @(negedge Clock);
        Tick = 1'b1;
        @(negedge Clock);
        Tick = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset_n = 1'b0;
        Left = 0; Right = 0; Hazard = 0; Brake = 0;
        repeat (2) @(negedge Clock);
        Reset_n = 1'b1;
    endtask

    int lseq[5]  = '{1, 3, 7, 0, 1};
    int preseq[9] = '{0, 0, 1, 1, 1, 3, 3, 3, 7};

    initial begin
        // Reset held with Left and Tick active: lamps stay dark.
        Left = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pulse(0);
            chk("rst_L", int'(L0), 0); chk("rst_R", int'(R0), 0); chk("rst_busy", int'(B0), 0);
        end
        Reset_n = 1'b1;

        // Left sequence on the TICKS_PER_STEP=1 instance.
        for (int i = 0; i < 5; i++) begin
            pulse(9);
            chk("left_seq_L", int'(L0), lseq[i]);
            chk("left_seq_R", int'(R0), 0);
        end

        // Prescale by 3 on the second instance.
        do_reset();
        Left = 1'b1;
        for (int i = 0; i < 9; i++) begin
            pulse(9);
            chk("prescale_L", int'(L1), preseq[i]);
        end

        // Abandon a right sequence in R2 by switching to Left.
        do_reset();
        Right = 1'b1;
        pulse(9);
        pulse(9);
        chk("abandon_R2", int'(R0), 3);
        Right = 1'b0;
        Left  = 1'b1;
        pulse(9);
        chk("abandon_idle_R", int'(R0), 0);
        chk("abandon_idle_L", int'(L0), 0);
        pulse(9);
        chk("abandon_L1", int'(L0), 1);

        // Left+Right behaves as hazard.
        do_reset();
        Left = 1'b1;
        Right = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pulse(9);
            chk("haz_LR_L", int'(L0), (i % 2 == 0) ? 7 : 0);
            chk("haz_LR_R", int'(R0), (i % 2 == 0) ? 7 : 0);
        end

        // Hazard asserted from L2.
        do_reset();
        Left = 1'b1;
        pulse(9);
        pulse(9);
        chk("haz_from_L2_pre", int'(L0), 3);
        Hazard = 1'b1;
        pulse(9);
        chk("haz_from_L2_L", int'(L0), 7);
        chk("haz_from_L2_R", int'(R0), 7);

`ifdef TAILLIGHT_BRAKE_EN
        do_reset();
        Left = 1'b1;
        pulse(9);
        pulse(9);
        Brake = 1'b1;
        repeat (5) @(negedge Clock);
        chk("brake_L2_L", int'(L0), 3);
        chk("brake_L2_R", int'(R0), 7);
        Left = 1'b0;
        pulse(5);
        chk("brake_idle_L", int'(L0), 7);
        chk("brake_idle_R", int'(R0), 7);
        chk("brake_idle_busy", int'(B0), 0);
`endif

        // Randomized phase, including occasional mid-sequence resets and held Tick.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            @(negedge Clock);
            Reset_n = ($urandom_range(0, 299) != 0);
            Tick    = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) Left   = $urandom_range(0, 1);
            if ($urandom_range(0, 19) == 0) Right  = $urandom_range(0, 1);
            if ($urandom_range(0, 39) == 0) Hazard = ($urandom_range(0, 2) == 0);
`ifdef TAILLIGHT_BRAKE_EN
            if ($urandom_range(0, 29) == 0) Brake  = $urandom_range(0, 1);
`endif
        end

        @(negedge Clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
